// File: rtl/ninjakun_pkg.sv
// Shared types and constants for the Ninjakun shared-bus arbiter.
// Imported by the arbiter top.
package ninjakun_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  localparam int ACCLEN_MAX = 15;

  localparam logic [7:0] ID_RESET = 8'hFF;

endpackage

// File: rtl/ninjakun_shbus_arb_if.sv
// Two CPU request ports plus the shared I/O-video bus.
// slave: the arbiter side; master: the CPUs and bus device.
interface ninjakun_shbus_arb_if;

  logic        CP0REQ;
  logic [15:0] CP0AD;
  logic [7:0]  CP0OD;
  logic        CP0RD;
  logic        CP0WR;
  logic        CP0ACK;
  logic [7:0]  CP0ID;

  logic        CP1REQ;
  logic [15:0] CP1AD;
  logic [7:0]  CP1OD;
  logic        CP1RD;
  logic        CP1WR;
  logic        CP1ACK;
  logic [7:0]  CP1ID;

  logic [15:0] CPADR;
  logic [7:0]  CPODT;
  logic [7:0]  CPIDT;
  logic        CPRED;
  logic        CPWRT;
  logic        BUSY;

  modport slave (
    input  CP0REQ, CP0AD, CP0OD,
    input  CP0RD, CP0WR,
    output CP0ACK, CP0ID,
    input  CP1REQ, CP1AD, CP1OD,
    input  CP1RD, CP1WR,
    output CP1ACK, CP1ID,
    output CPADR, CPODT,
    output CPRED, CPWRT, BUSY,
    input  CPIDT
  );

  modport master (
    output CP0REQ, CP0AD, CP0OD,
    output CP0RD, CP0WR,
    input  CP0ACK, CP0ID,
    output CP1REQ, CP1AD, CP1OD,
    output CP1RD, CP1WR,
    input  CP1ACK, CP1ID,
    input  CPADR, CPODT,
    input  CPRED, CPWRT, BUSY,
    output CPIDT
  );

endinterface

// File: rtl/ninjakun_rr2.sv
// Two-way round-robin picker; the caller keeps the last-grant bit.
// On contention the port that was not granted last wins.
module ninjakun_rr2 (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic       o_gnt_valid,
  output logic       o_gnt_id
);

  always_comb begin
    o_gnt_valid = |i_req;
    o_gnt_id    = 1'b0;
    if (i_req == 2'b11) begin
      o_gnt_id = ~i_last;
    end else begin
      o_gnt_id = i_req[1];
    end
  end

endmodule

// File: rtl/ninjakun_shbus_arb.sv
// Demand-driven round-robin arbiter sharing the I/O-video bus
// between the two Z80s: IDLE grant, ACCESS for ACCLEN cycles, DONE ack.
module ninjakun_shbus_arb #(
  parameter int ACCLEN = 2
) (
  input  logic               SHCLK,
  input  logic               RESET,
  ninjakun_shbus_arb_if.slave bus
);

  import ninjakun_pkg::*;

  localparam int CW = $clog2(ACCLEN_MAX + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(ACCLEN - 1);

  state_t        r_state;
  state_t        w_state_nx;
  logic          r_last;
  logic          r_gid;
  logic [CW-1:0] r_cnt;
  logic [15:0]   r_adr;
  logic [7:0]    r_odt;
  logic          r_red;
  logic          r_wrt;
  logic          r_busy;
  logic          r_ack0;
  logic          r_ack1;
  logic [7:0]    r_id0;
  logic [7:0]    r_id1;
  logic          w_gnt_valid;
  logic          w_gnt_id;

  ninjakun_rr2 u_rr2 (
    .i_req       ({bus.CP1REQ, bus.CP0REQ}),
    .i_last      (r_last),
    .o_gnt_valid (w_gnt_valid),
    .o_gnt_id    (w_gnt_id)
  );

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      IDLE:    if (w_gnt_valid) w_state_nx = ACCESS;
      ACCESS:  if (r_cnt == '0) w_state_nx = DONE;
      DONE:    w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge SHCLK) begin
    if (RESET) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_gid   <= 1'b0;
      r_cnt   <= '0;
      r_adr   <= '0;
      r_odt   <= '0;
      r_red   <= 1'b0;
      r_wrt   <= 1'b0;
      r_busy  <= 1'b0;
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
      r_id0   <= ID_RESET;
      r_id1   <= ID_RESET;
    end else begin
      r_state <= w_state_nx;
      r_busy  <= (w_state_nx != IDLE);
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_gnt_valid) begin
            r_last <= w_gnt_id;
            r_gid  <= w_gnt_id;
            r_cnt  <= CNT_INIT;
            r_adr  <= w_gnt_id ? bus.CP1AD : bus.CP0AD;
            r_odt  <= w_gnt_id ? bus.CP1OD : bus.CP0OD;
            r_red  <= w_gnt_id ? bus.CP1RD : bus.CP0RD;
            r_wrt  <= w_gnt_id ? bus.CP1WR : bus.CP0WR;
          end
        end
        ACCESS: begin
          // last bus cycle: capture, release the bus, ack next cycle
          if (r_cnt == '0) begin
            if (r_gid) r_id1 <= bus.CPIDT;
            else       r_id0 <= bus.CPIDT;
            r_adr  <= '0;
            r_odt  <= '0;
            r_red  <= 1'b0;
            r_wrt  <= 1'b0;
            r_ack0 <= ~r_gid;
            r_ack1 <= r_gid;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.CPADR  = r_adr;
  assign bus.CPODT  = r_odt;
  assign bus.CPRED  = r_red;
  assign bus.CPWRT  = r_wrt;
  assign bus.BUSY   = r_busy;
  assign bus.CP0ACK = r_ack0;
  assign bus.CP1ACK = r_ack1;
  assign bus.CP0ID  = r_id0;
  assign bus.CP1ID  = r_id1;

endmodule

// File: tb/tb_ninjakun_shbus_arb.sv
// Directed bench for ninjakun_shbus_arb: ACCLEN 2, 1 and 15 builds
// share stimulus; one build is observed at a time via sel.
module tb_ninjakun_shbus_arb;

  typedef struct {
    int          sel;
    logic        port;
    logic        rd;
    logic        wr;
    logic [15:0] ad;
    logic [7:0]  od;
    logic [7:0]  idt;
    logic [7:0]  id0;
    logic [7:0]  id1;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cp0req, cp0rd, cp0wr;
  logic [15:0] cp0ad;
  logic [7:0]  cp0od;
  logic        cp1req, cp1rd, cp1wr;
  logic [15:0] cp1ad;
  logic [7:0]  cp1od;
  logic [7:0]  cpidt;

  logic        o_ack0 [3];
  logic        o_ack1 [3];
  logic        o_red  [3];
  logic        o_wrt  [3];
  logic        o_busy [3];
  logic [15:0] o_adr  [3];
  logic [7:0]  o_odt  [3];
  logic [7:0]  o_id0  [3];
  logic [7:0]  o_id1  [3];

  int checks   = 0;
  int failures = 0;
  int sel      = 0;
  vec_t tv [7];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int ACC = (g == 0) ? 2 : (g == 1) ? 1 : 15;
    ninjakun_shbus_arb_if bus ();
    assign bus.CP0REQ = cp0req;
    assign bus.CP0AD  = cp0ad;
    assign bus.CP0OD  = cp0od;
    assign bus.CP0RD  = cp0rd;
    assign bus.CP0WR  = cp0wr;
    assign bus.CP1REQ = cp1req;
    assign bus.CP1AD  = cp1ad;
    assign bus.CP1OD  = cp1od;
    assign bus.CP1RD  = cp1rd;
    assign bus.CP1WR  = cp1wr;
    assign bus.CPIDT  = cpidt;
    assign o_ack0[g]  = bus.CP0ACK;
    assign o_ack1[g]  = bus.CP1ACK;
    assign o_red[g]   = bus.CPRED;
    assign o_wrt[g]   = bus.CPWRT;
    assign o_busy[g]  = bus.BUSY;
    assign o_adr[g]   = bus.CPADR;
    assign o_odt[g]   = bus.CPODT;
    assign o_id0[g]   = bus.CP0ID;
    assign o_id1[g]   = bus.CP1ID;
    ninjakun_shbus_arb #(.ACCLEN(ACC)) u_dut (
      .SHCLK (clk),
      .RESET (rst),
      .bus   (bus)
    );
  end

  task automatic chk(input string nm, input int c,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s c%0d: got %h want %h", nm, c, act, exp);
    end
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    cp0req = 0; cp0rd = 0; cp0wr = 0;
    cp0ad  = '0; cp0od = '0;
    cp1req = 0; cp1rd = 0; cp1wr = 0;
    cp1ad  = '0; cp1od = '0;
    cpidt  = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic do_txn(input vec_t v);
    int a;
    a = (v.sel == 0) ? 2 : (v.sel == 1) ? 1 : 15;
    @(posedge clk); #1;
    if (v.port) begin
      cp1req = 1; cp1ad = v.ad; cp1od = v.od;
      cp1rd = v.rd; cp1wr = v.wr;
    end else begin
      cp0req = 1; cp0ad = v.ad; cp0od = v.od;
      cp0rd = v.rd; cp0wr = v.wr;
    end
    cpidt = ~v.idt;
    @(negedge clk);
    chk("idle_busy", 0, o_busy[sel], 0);
    for (int k = 1; k <= a; k++) begin
      @(negedge clk);
      chk("bus_adr", k, o_adr[sel], v.ad);
      chk("bus_odt", k, o_odt[sel], v.od);
      chk("bus_red", k, o_red[sel], v.rd);
      chk("bus_wrt", k, o_wrt[sel], v.wr);
      chk("bus_busy", k, o_busy[sel], 1);
      chk("early_ack", k, {o_ack1[sel], o_ack0[sel]}, 0);
      cpidt = (k == a) ? v.idt : ~v.idt;
    end
    @(negedge clk);
    chk("ack0", a + 1, o_ack0[sel], !v.port);
    chk("ack1", a + 1, o_ack1[sel], v.port);
    chk("id0", a + 1, o_id0[sel], v.id0);
    chk("id1", a + 1, o_id1[sel], v.id1);
    chk("done_red", a + 1, o_red[sel], 0);
    chk("done_wrt", a + 1, o_wrt[sel], 0);
    chk("done_adr", a + 1, o_adr[sel], 0);
    chk("done_busy", a + 1, o_busy[sel], 1);
    cpidt = 8'h00;
    @(posedge clk); #1;
    cp0req = 0; cp1req = 0;
    @(negedge clk);
    chk("post_ack", a + 2, {o_ack1[sel], o_ack0[sel]}, 0);
    chk("post_busy", a + 2, o_busy[sel], 0);
    chk("hold_id0", a + 2, o_id0[sel], v.id0);
    chk("hold_id1", a + 2, o_id1[sel], v.id1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] ea;
    tv[0] = '{0, 1'b0, 1'b1, 1'b0, 16'hC800, 8'h00, 8'h5A, 8'h5A, 8'hFF};
    tv[1] = '{0, 1'b1, 1'b0, 1'b1, 16'hD000, 8'h3C, 8'hFF, 8'h5A, 8'hFF};
    tv[2] = '{0, 1'b0, 1'b0, 1'b0, 16'h1234, 8'h77, 8'h11, 8'h11, 8'hFF};
    tv[3] = '{0, 1'b1, 1'b1, 1'b1, 16'hFFFF, 8'hA5, 8'hC3, 8'h11, 8'hC3};
    tv[4] = '{0, 1'b1, 1'b1, 1'b0, 16'h0001, 8'h00, 8'h00, 8'h11, 8'h00};
    tv[5] = '{1, 1'b0, 1'b1, 1'b0, 16'h8000, 8'h00, 8'h96, 8'h96, 8'hFF};
    tv[6] = '{2, 1'b1, 1'b1, 1'b0, 16'hE123, 8'h00, 8'h4B, 8'hFF, 8'h4B};

    do_reset();
    @(negedge clk);
    chk("rst_adr", 0, o_adr[0], 0);
    chk("rst_odt", 0, o_odt[0], 0);
    chk("rst_red", 0, o_red[0], 0);
    chk("rst_wrt", 0, o_wrt[0], 0);
    chk("rst_busy", 0, o_busy[0], 0);
    chk("rst_ack", 0, {o_ack1[0], o_ack0[0]}, 0);
    chk("rst_id0", 0, o_id0[0], 8'hFF);
    chk("rst_id1", 0, o_id1[0], 8'hFF);

    for (int i = 0; i < 7; i++) begin
      if (i > 0 && tv[i].sel != tv[i-1].sel) do_reset();
      sel = tv[i].sel;
      do_txn(tv[i]);
    end

    // contention: alternating grants with 4-cycle spacing
    sel = 0;
    do_reset();
    cp0ad = 16'h1000; cp0rd = 1;
    cp1ad = 16'h2000; cp1rd = 1;
    cpidt = 8'h42;
    for (int c = 0; c <= 16; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin cp0req = 1; cp1req = 1; end
      @(negedge clk);
      ea = 16'h0;
      if (c % 4 == 1 || c % 4 == 2)
        ea = ((c / 4) % 2 == 0) ? 16'h1000 : 16'h2000;
      chk("rr_adr", c, o_adr[0], ea);
      chk("rr_ack0", c, o_ack0[0], c % 8 == 3);
      chk("rr_ack1", c, o_ack1[0], c % 8 == 7);
    end

    // late request from CPU1 during CPU0 access
    do_reset();
    cp0ad = 16'hC000; cp0rd = 1;
    cp1ad = 16'h2222; cp1rd = 1;
    for (int c = 0; c <= 9; c++) begin
      @(posedge clk); #1;
      if (c == 0) cp0req = 1;
      if (c == 1) cp1req = 1;
      if (c == 4) cp0req = 0;
      if (c == 8) cp1req = 0;
      @(negedge clk);
      ea = 16'h0;
      if (c == 1 || c == 2) ea = 16'hC000;
      if (c == 5 || c == 6) ea = 16'h2222;
      chk("late_adr", c, o_adr[0], ea);
      chk("late_red", c, o_red[0], ea != 0);
      chk("late_ack0", c, o_ack0[0], c == 3);
      chk("late_ack1", c, o_ack1[0], c == 7);
    end

    // reset in CPU0 bus cycle 1, then CPU0 wins contention again
    do_reset();
    cp0ad = 16'h4444; cp0rd = 1;
    cp1ad = 16'h5555; cp1rd = 1;
    cpidt = 8'h99;
    for (int c = 0; c <= 6; c++) begin
      @(posedge clk); #1;
      if (c == 0) cp0req = 1;
      if (c == 1) begin rst = 1; cp1req = 1; end
      if (c == 2) rst = 0;
      if (c == 6) begin cp0req = 0; cp1req = 0; end
      @(negedge clk);
      ea = 16'h0;
      if (c == 1 || c == 3 || c == 4) ea = 16'h4444;
      chk("mrst_adr", c, o_adr[0], ea);
      chk("mrst_red", c, o_red[0], ea != 0);
      chk("mrst_ack0", c, o_ack0[0], c == 5);
      chk("mrst_ack1", c, o_ack1[0], 0);
      if (c == 2) begin
        chk("mrst_busy", c, o_busy[0], 0);
        chk("mrst_id0", c, o_id0[0], 8'hFF);
      end
      if (c == 5) chk("mrst_rid0", c, o_id0[0], 8'h99);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
